// File: rtl/alu_sout_decoder.sv
// alu_sout_decoder: deserializes ALU sout frames into result / error packets with CRC3 and parity checks
module alu_sout_decoder #(
  parameter int         DATA_BYTES = 4,
  parameter logic [2:0] CRC_POLY   = 3'b011
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sout,
  output logic                    res_valid,
  output logic [8*DATA_BYTES-1:0] res_c,
  output logic [3:0]              res_flags,
  output logic                    res_crc_ok,
  output logic                    err_valid,
  output logic [5:0]              err_flags,
  output logic                    err_parity_ok,
  output logic                    frame_err
);
  localparam int         CW     = $clog2(DATA_BYTES + 1);
  localparam int         RW     = 8 * DATA_BYTES;
  localparam logic [CW-1:0] FULL = CW'(DATA_BYTES);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] TYPE   = 3'd1;
  localparam logic [2:0] BITS   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
  localparam logic [2:0] RESYNC = 3'd4;

  logic [2:0]    st_q, st_d, bc_q, bc_d;
  logic          ty_q, ty_d;
  logic [7:0]    sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] c_q, c_d, res_c_q, res_c_d;
  logic [3:0]    res_flags_q, res_flags_d;
  logic [5:0]    err_flags_q, err_flags_d;
  logic          res_valid_q, res_valid_d, res_crc_ok_q, res_crc_ok_d;
  logic          err_valid_q, err_valid_d, err_par_q, err_par_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    crc_calc;

  // Serial CRC3 over the message MSB first; the line CRC covers {C, 0, flags}
  function automatic logic [2:0] crc3(input logic [RW+4:0] m);
    logic [2:0] c;
    logic       fb;
    c = 3'b000;
    for (int i = RW + 4; i >= 0; i--) begin
      fb = m[i] ^ c[2];
      c  = {c[1:0], 1'b0} ^ (fb ? CRC_POLY : 3'b000);
    end
    return c;
  endfunction

  assign crc_calc = crc3({c_q, 1'b0, sh_q[6:3]});

  // Bit-level framing FSM plus packet assembly, evaluated on the stop-bit cycle
  always_comb begin
    st_d        = st_q;
    bc_d        = bc_q;
    ty_d        = ty_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    c_d         = c_q;
    res_c_d     = res_c_q;
    res_flags_d = res_flags_q;
    res_crc_ok_d = res_crc_ok_q;
    err_flags_d = err_flags_q;
    err_par_d   = err_par_q;
    res_valid_d = 1'b0;
    err_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (st_q)
      IDLE: st_d = sout ? IDLE : TYPE;
      TYPE: begin
        ty_d = sout;
        bc_d = 3'd0;
        st_d = BITS;
      end
      BITS: begin
        sh_d = {sh_q[6:0], sout};
        bc_d = bc_q + 3'd1;
        st_d = (bc_q == 3'd7) ? STOP : BITS;
      end
      STOP: begin
        st_d = sout ? IDLE : RESYNC;
        if (!sout) frame_err_d = 1'b1;
        else if (!ty_q) begin
          if (cnt_q != FULL) begin
            c_d   = {c_q[RW-9:0], sh_q};
            cnt_d = cnt_q + 1'b1;
          end else frame_err_d = 1'b1;
        end else if (cnt_q == FULL && !sh_q[7]) begin
          res_valid_d  = 1'b1;
          res_c_d      = c_q;
          res_flags_d  = sh_q[6:3];
          res_crc_ok_d = (crc_calc == sh_q[2:0]);
        end else if (cnt_q == '0 && sh_q[7]) begin
          err_valid_d = 1'b1;
          err_flags_d = sh_q[6:1];
          err_par_d   = ~^sh_q;
        end else frame_err_d = 1'b1;
        if (res_valid_d || frame_err_d) begin
          cnt_d = '0;
          c_d   = '0;
        end
      end
      RESYNC: st_d = sout ? IDLE : RESYNC;
      default: st_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= IDLE;
      bc_q         <= '0;
      ty_q         <= 1'b0;
      sh_q         <= '0;
      cnt_q        <= '0;
      c_q          <= '0;
      res_c_q      <= '0;
      res_flags_q  <= '0;
      res_crc_ok_q <= 1'b0;
      err_flags_q  <= '0;
      err_par_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      err_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      st_q         <= st_d;
      bc_q         <= bc_d;
      ty_q         <= ty_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      c_q          <= c_d;
      res_c_q      <= res_c_d;
      res_flags_q  <= res_flags_d;
      res_crc_ok_q <= res_crc_ok_d;
      err_flags_q  <= err_flags_d;
      err_par_q    <= err_par_d;
      res_valid_q  <= res_valid_d;
      err_valid_q  <= err_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign res_valid     = res_valid_q;
  assign res_c         = res_c_q;
  assign res_flags     = res_flags_q;
  assign res_crc_ok    = res_crc_ok_q;
  assign err_valid     = err_valid_q;
  assign err_flags     = err_flags_q;
  assign err_parity_ok = err_par_q;
  assign frame_err     = frame_err_q;
endmodule

// File: tb/tb_alu_sout_decoder.sv
// tb_alu_sout_decoder: directed and randomized checks of the sout decoder against a packet-level model
module tb_alu_sout_decoder;
  logic        clk = 1'b0;
  logic        rst_n, sout;
  logic        res_valid, res_crc_ok, err_valid, err_parity_ok, frame_err;
  logic [31:0] res_c;
  logic [3:0]  res_flags;
  logic [5:0]  err_flags;
  int checks = 0, errors = 0;
  int n_res = 0, n_err = 0, n_fe = 0, n_both = 0;
  int b_res = 0, b_err = 0, b_fe = 0;

  alu_sout_decoder dut (
    .clk(clk), .rst_n(rst_n), .sout(sout),
    .res_valid(res_valid), .res_c(res_c), .res_flags(res_flags), .res_crc_ok(res_crc_ok),
    .err_valid(err_valid), .err_flags(err_flags), .err_parity_ok(err_parity_ok),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (res_valid) n_res <= n_res + 1;
    if (err_valid) n_err <= n_err + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (res_valid && err_valid) n_both <= n_both + 1;
  end

  // CRC as the remainder of message * x^3 divided by x^3+x+1
  function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
    logic [39:0] r;
    r = {c, 1'b0, f, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r = r ^ (40'hB << (i - 3));
    return r[2:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bitv(input logic v);
    sout = v;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bitv(1'b1);
  endtask

  task automatic frame(input logic t, input logic [7:0] b, input logic stp = 1'b1);
    bitv(1'b0);
    bitv(t);
    for (int i = 7; i >= 0; i--) bitv(b[i]);
    bitv(stp);
  endtask

  task automatic counts(input string tag, input int er, input int ee, input int ef);
    idle(3);
    chk({tag, "_res_cnt"}, n_res - b_res, er);
    chk({tag, "_err_cnt"}, n_err - b_err, ee);
    chk({tag, "_fe_cnt"}, n_fe - b_fe, ef);
    b_res = n_res;
    b_err = n_err;
    b_fe  = n_fe;
  endtask

  task automatic send_res(input logic [31:0] c, input logic [3:0] f, input logic [2:0] crc, input int maxgap);
    for (int k = 0; k < 4; k++) begin
      frame(1'b0, c[31-8*k -: 8]);
      idle($urandom_range(maxgap));
    end
    frame(1'b1, {1'b0, f, crc});
  endtask

  task automatic check_res(input string tag, input logic [31:0] c, input logic [3:0] f, input logic ok);
    counts(tag, 1, 0, 0);
    chk({tag, "_c"}, res_c, c);
    chk({tag, "_flags"}, {28'd0, res_flags}, {28'd0, f});
    chk({tag, "_crc_ok"}, {31'd0, res_crc_ok}, {31'd0, ok});
  endtask

  task automatic check_err(input string tag, input logic [7:0] p);
    counts(tag, 0, 1, 0);
    chk({tag, "_flags"}, {26'd0, err_flags}, {26'd0, p[6:1]});
    chk({tag, "_par"}, {31'd0, err_parity_ok}, {31'd0, ($countones(p) % 2) == 0});
  endtask

  initial begin
    logic [31:0] c;
    logic [3:0]  f;
    logic [2:0]  crc;
    logic [7:0]  p;
    logic        good;
    rst_n = 1'b0;
    sout  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_c", res_c, 32'd0);
    chk("rst_outs", {18'd0, res_flags, res_crc_ok, err_valid, err_flags, err_parity_ok, frame_err}, 32'd0);
    rst_n = 1'b1;
    idle(2);
    // zero packet, back-to-back frames
    send_res(32'h0, 4'b0010, 3'b110, 0);
    check_res("zero_ok", 32'h0, 4'b0010, 1'b1);
    send_res(32'h0, 4'b0010, 3'b111, 0);
    check_res("zero_badcrc", 32'h0, 4'b0010, 1'b0);
    // error packets
    frame(1'b1, 8'h93);
    check_err("err93", 8'h93);
    frame(1'b1, 8'h92);
    check_err("err92", 8'h92);
    // DEADBEEF with idle gaps
    send_res(32'hDEADBEEF, 4'b1001, ref_crc(32'hDEADBEEF, 4'b1001), 5);
    check_res("deadbeef", 32'hDEADBEEF, 4'b1001, 1'b1);
    // protocol errors
    frame(1'b0, 8'h11);
    frame(1'b0, 8'h22);
    frame(1'b1, 8'h16);
    counts("short_pkt", 0, 0, 1);
    frame(1'b0, 8'h33, 1'b0);
    counts("bad_stop", 0, 0, 1);
    for (int k = 0; k < 5; k++) frame(1'b0, 8'(k + 1));
    counts("fifth_data", 0, 0, 1);
    frame(1'b1, 8'h80);
    frame(1'b1, 8'h16);
    counts("ctl_wrong_cnt", 0, 1, 1);
    send_res(32'h12345678, 4'b0110, ref_crc(32'h12345678, 4'b0110), 2);
    check_res("recover", 32'h12345678, 4'b0110, 1'b1);
    // reset during third payload bit of the CTL frame
    for (int k = 0; k < 4; k++) frame(1'b0, 8'hA5);
    bitv(1'b0);
    bitv(1'b1);
    bitv(1'b0);
    bitv(1'b0);
    rst_n = 1'b0;
    sout  = 1'b1;
    @(negedge clk);
    chk("midrst_res_c", res_c, 32'd0);
    chk("midrst_outs", {18'd0, res_flags, res_crc_ok, err_valid, err_flags, err_parity_ok, frame_err}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(12);
    counts("midrst", 0, 0, 0);
    send_res(32'hCAFEF00D, 4'b0101, ref_crc(32'hCAFEF00D, 4'b0101), 3);
    check_res("after_rst", 32'hCAFEF00D, 4'b0101, 1'b1);
    // randomized packets
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(3) == 0) begin
        p = {1'b1, 7'($urandom)};
        frame(1'b1, p);
        check_err("rnd_err", p);
      end else begin
        c    = $urandom;
        f    = 4'($urandom);
        good = $urandom_range(1) == 1;
        crc  = good ? ref_crc(c, f) : ref_crc(c, f) ^ 3'(1 + $urandom_range(6));
        send_res(c, f, crc, 4);
        check_res("rnd_res", c, f, good);
      end
    end
    chk("never_both", n_both, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
